// File: rtl/seg_scan.sv
// seg_scan: six-digit multiplexed 7-segment back end with
// anti-ghost guard, double-buffered frames and alarm blinking.
module seg_scan #(
  parameter int CLK_DIV   = 50000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] frame,
  input  logic        alarm,
  input  logic        blank,
  output logic [7:0]  seg,
  output logic [5:0]  an,
  output logic        frame_ack
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GRD_N   = PW'(GUARD);
  localparam logic [SW-1:0] BLK_MAX = SW'(BLINK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [2:0]    r_dig;
  logic [47:0]   r_shadow;
  logic [SW-1:0] r_scan;
  logic          r_blink_ph;

  logic       w_tick;
  logic       w_wrap;
  logic       w_vis;
  logic       w_dark;
  logic [7:0] w_pat;
  logic [5:0] w_an;

  assign w_tick = (r_pre == PRE_MAX);
  assign w_wrap = w_tick && (r_dig == 3'd5);
  // Dropping alarm must relight the display without waiting for a register.
  assign w_vis  = ~alarm | r_blink_ph;
  assign w_dark = (r_pre < GRD_N) | blank | ~w_vis;
  assign w_an   = ~(6'b1 << r_dig);

  always_comb begin
    w_pat = 8'h00;
    unique case (r_dig)
      3'd0:    w_pat = r_shadow[7:0];
      3'd1:    w_pat = r_shadow[15:8];
      3'd2:    w_pat = r_shadow[23:16];
      3'd3:    w_pat = r_shadow[31:24];
      3'd4:    w_pat = r_shadow[39:32];
      3'd5:    w_pat = r_shadow[47:40];
      default: w_pat = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_dig <= 3'd0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_dig <= (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Shadow only reloads between scans so a scan never mixes two frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= 48'h0;
      frame_ack <= 1'b0;
    end else begin
      frame_ack <= w_wrap;
      if (w_wrap) r_shadow <= frame;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan     <= '0;
      r_blink_ph <= 1'b1;
    end else if (!alarm) begin
      r_scan     <= '0;
      r_blink_ph <= 1'b1;
    end else if (w_wrap) begin
      if (r_scan == BLK_MAX) begin
        r_scan     <= '0;
        r_blink_ph <= ~r_blink_ph;
      end else begin
        r_scan <= r_scan + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= 6'h3F;
    end else begin
      seg <= ~w_pat;
      an  <= w_dark ? 6'h3F : w_an;
    end
  end

endmodule
